// File: rtl/insmemory_param.sv
// Instruction memory for the IF stage: registered fetch with stall/flush,
// fault detection, streaming program load and a post-reset NOP clear sweep.
module insmemory_param #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter logic [31:0] NOP    = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              stall,
  input  logic              flush,
  input  logic [XLEN-1:0]   pc_out,
  output logic [31:0]       instruction,
  output logic              ins_valid,
  output logic              fetch_fault,
  output logic              mem_ready,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [31:0]       mem_q [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;

  logic              we;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] fetch_idx_c;
  logic              fetch_fault_c;

  // Word index and fault decode for the presented PC
  always_comb begin
    fetch_idx_c   = pc_out[ADDR_W+1:2];
    fetch_fault_c = (pc_out[1:0] != 2'b00) || ((pc_out >> (ADDR_W + 2)) != '0);
  end

  // Next-state, write-port and output-register logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    fault_d = 1'b0;
    we      = 1'b0;
    wdata   = NOP;

    case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        ptr_d = ADDR_W'(ptr_q + 1'b1);
        if (ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (flush) begin
          instr_d = NOP;
        end else if (stall) begin
          valid_d = valid_q;
          fault_d = fault_q;
        end else if (fetch_en && !load_start) begin
          valid_d = 1'b1;
          if (fetch_fault_c) begin
            instr_d = NOP;
            fault_d = 1'b1;
          end else begin
            instr_d = mem_q[fetch_idx_c];
          end
        end
        // Entering LOAD suppresses any fetch result this cycle
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          fault_d = 1'b0;
        end
      end

      ST_LOAD: begin
        if (load_valid) begin
          we    = 1'b1;
          wdata = load_data;
          ptr_d = ADDR_W'(ptr_q + 1'b1);
          cnt_d = (ADDR_W + 1)'(cnt_q + 1'b1);
          // Stop on the last beat or once the top word is written; never wrap
          if (load_last || (ptr_q == LAST_IDX)) begin
            state_d = ST_RUN;
          end
        end
      end

      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      cnt_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Single write port shared by the clear sweep and the load stream
  always_ff @(posedge clk) begin
    if (rst && we) begin
      mem_q[ptr_q] <= wdata;
    end
  end

  assign instruction = instr_q;
  assign ins_valid   = valid_q;
  assign fetch_fault = fault_q;
  assign load_count  = cnt_q;
  assign mem_ready   = (state_q == ST_RUN);
  assign load_ready  = (state_q == ST_LOAD);

endmodule

// File: doc/insmemory_param.md
Name:
insmemory_param

Overview:
- Parametrised instruction memory for the pipelined core's IF stage.
- Supplies one 32-bit instruction per cycle from a byte-addressed PC, with registered read, stall/flush control and misaligned/out-of-range fault detection.
- Adds a streaming program-load port and a sequential post-reset clear sweep, replacing the single-cycle loop clear.

Parameters:
XLEN, 32, PC width in bits.
DEPTH, 16, number of 32-bit instruction words (power of two, >=4).
ADDR_W, $clog2(DEPTH), word index width.
NOP, 32'h00000013, value used for cleared words and injected bubbles (addi x0,x0,0).

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, synchronous, active-low
fetch_en  input  1  request fetch at pc_out this cycle
stall  input  1  hold IF outputs
flush  input  1  kill fetched instruction (branch/jump redirect)
pc_out  input  XLEN  byte address of instruction
instruction  output  32  registered fetched instruction
ins_valid  output  1  instruction is a real fetch result
fetch_fault  output  1  fetch was misaligned or out of range
mem_ready  output  1  block is in RUN and accepts fetches
load_start  input  1  request entry to LOAD (honoured only in RUN)
load_valid  input  1  load_data is valid
load_data  input  32  word to write
load_last  input  1  final word of the program
load_ready  output  1  block accepts a load word this cycle
load_count  output  ADDR_W+1  words written in the current load session

Behaviour:
- Reset: sampled only on rising clk while rst==0.
  - Reset values: state=CLEAR, clear pointer=0, instruction=NOP, ins_valid=0, fetch_fault=0, load_count=0.
  - mem_ready and load_ready are decoded from state, so both read 0 in CLEAR.
  - Array contents are not reset in the same cycle; the CLEAR sweep overwrites them.
- States: CLEAR, RUN, LOAD.
- CLEAR:
  - Writes NOP to mem[ptr] each cycle; ptr increments.
  - After writing index DEPTH-1, transitions to RUN, so CLEAR lasts exactly DEPTH cycles after rst release.
  - Fetch, flush and load_start are ignored; ins_valid=0.
- RUN (mem_ready=1):
  - Fetch index = pc_out[ADDR_W+1:2].
  - Fault = (pc_out[1:0]!=0) OR (pc_out[XLEN-1:ADDR_W+2]!=0).
  - Priority per cycle, highest first:
    1. flush: instruction<=NOP, ins_valid<=0, fetch_fault<=0.
    2. stall: all outputs hold.
    3. fetch_en, no fault: instruction<=mem[index], ins_valid<=1, fetch_fault<=0.
    4. fetch_en, fault: instruction<=NOP, ins_valid<=1, fetch_fault<=1.
    5. otherwise: instruction holds, ins_valid<=0, fetch_fault<=0.
  - Read latency is 1 cycle: pc presented at edge N gives its instruction after edge N.
  - load_start=1: next state LOAD, load pointer<=0, load_count<=0, ins_valid<=0. load_start takes precedence over a same-cycle fetch.
- LOAD (load_ready=1, mem_ready=0):
  - Handshake fires on load_valid && load_ready: mem[ptr]<=load_data, ptr++, load_count++.
  - Exits to RUN on a fired beat with load_last=1, or on the beat writing index DEPTH-1 (auto-terminate).
  - load_ready falls the cycle after the final beat; extra words are never accepted and the pointer never wraps.
  - Words beyond the last loaded index keep their prior contents.
  - Fetch, stall, flush and load_start are ignored; ins_valid=0, instruction holds.
  - load_count keeps its final value in RUN until the next load_start or reset.
- Reset mid-CLEAR or mid-LOAD: aborts the operation and restarts CLEAR from index 0; any partial load is discarded by the sweep.
- No combinational path from fetch inputs to outputs; mem_ready and load_ready depend only on state.

Test Plan:
- Reset sweep: rst=0 for 2 cycles, then 1 -> mem_ready rises exactly 16 cycles later; fetch pc=0x0 gives instruction=0x00000013, ins_valid=1, fetch_fault=0.
- Load then fetch: load_start, then 4 beats 0x11111111..0x44444444 with load_last on beat 4 -> load_count=4, return to RUN; fetch pc=0x8 gives 0x33333333 one cycle later; pc=0x10 gives NOP.
- Faults: pc=0x6 -> NOP, ins_valid=1, fetch_fault=1; pc=0x40 (DEPTH=16) -> fetch_fault=1; pc=0x3C -> valid, no fault.
- Stall/flush: fetch 0x4, then stall=1 for 3 cycles with pc changing -> outputs frozen. Then flush=1 with stall=1 -> NOP, ins_valid=0.
- Load overflow: 20 beats with load_last never set -> exactly 16 accepted, load_count=16, load_ready low from cycle 17, RUN entered; mem[15]=beat 16.
- Reset mid-load: rst=0 after beat 2 -> 16-cycle CLEAR follows; fetch pc=0x0 returns NOP, not the loaded word.
